rs_layer_sequencer: RTL and testbench
=====================================

Name: rs_layer_sequencer

Overview:
Sequences the row-stationary PE_array over a full convolution layer that is larger than one array pass. Tiles output channels into groups of p*t and input channels into groups of q*r. Issues one begin_layer per pass, supplies filter/ifmap bank base addresses and psum clear/accumulate control, and hands each finished output-channel group to writeback. Sits between the host/config interface and PE_array.

Parameters:
ADDR_W, 20, width of filter_base/ifmap_base
CNT_W, 16, width of channel counts and group indices
TIMEOUT, 4096, max cycles in WAIT before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, starts a layer (sampled in IDLE only)
abort  in  1  synchronous abort, any state -> IDLE
cfg_M  in  CNT_W  output channels
cfg_C  in  CNT_W  input channels
cfg_H, cfg_W  in  8  ifmap height/width
cfg_R  in  5  filter height
cfg_S  in  4  filter width
cfg_p, cfg_r, cfg_t  in  5  PE_array mapping factors
cfg_q  in  3  PE_array mapping factor
begin_layer  out  1  one-cycle pass start to PE_array
PE_array_complete  in  1  pass-finished pulse from PE_array
filter_base  out  ADDR_W  filter bank word offset of current pass
ifmap_base  out  ADDR_W  ifmap bank word offset of current pass
psum_clear  out  1  1 = first input-channel pass (overwrite psums); 0 = accumulate
oc_idx, ic_idx  out  CNT_W  current output/input group index
wb_req  out  1  psum group ready for writeback
wb_ack  in  1  writeback accepted
busy  out  1  high from LOAD through DONE
done  out  1  one-cycle layer-finished pulse
err  out  1  sticky error flag
err_code  out  2  0 none, 1 zero config, 2 timeout

Behaviour:
- Reset: state IDLE; all outputs 0.
- cfg_* latched on accepted start; later cfg changes are ignored until the next start.
- IDLE: on start, if cfg_M==0, cfg_C==0, p*t==0 or q*r==0, go to ERR with err_code=1. Otherwise go to LOAD. A start received while busy is ignored.
- LOAD (1 cycle) computes:
  - n_oc = ceil(M/(p*t)), n_ic = ceil(C/(q*r))
  - FBLK = p*t*q*r*R*S, IBLK = q*r*H*W
  - oc_idx=ic_idx=0, filter_base=ifmap_base=0
  - Then go to ISSUE.
- ISSUE (1 cycle): begin_layer=1. filter_base, ifmap_base, psum_clear=(ic_idx==0), oc_idx and ic_idx hold stable from ISSUE through end of WAIT. A PE_array_complete in the ISSUE cycle is stale and ignored. Go to WAIT; timeout counter cleared.
- WAIT: counter increments each cycle.
  - On PE_array_complete: filter_base += FBLK.
    - If ic_idx==n_ic-1, go to WB.
    - Else ic_idx++, ifmap_base += IBLK, go to ISSUE.
  - If counter reaches TIMEOUT with no complete, go to ERR with err_code=2. Complete in that same cycle wins (no error).
- WB: wb_req=1 held until wb_ack is sampled high. No new begin_layer is issued while waiting.
  - If oc_idx==n_oc-1, go to DONE.
  - Else oc_idx++, ic_idx=0, ifmap_base=0, go to ISSUE.
- DONE (1 cycle): done=1, busy=0 on the next cycle, go to IDLE.
- ERR: busy=0; err/err_code stay sticky until abort or rst. start is ignored in ERR.
- abort: highest priority in every state. Next cycle is IDLE with begin_layer, wb_req, busy, err, err_code, and indices all 0.
- Address arithmetic is unsigned, truncated to ADDR_W; no overflow flag.
- Layer latency is 2 + sum over passes of (1 + PE cycles) + WB handshake cycles + 1.

Test Plan:
- M=2,C=2,p=q=r=t=1,R=S=3,H=W=5, complete 10 cycles after each begin_layer, wb_ack immediate -> 4 begin_layer pulses. filter_base 0,9,18,27. ifmap_base 0,25,0,25. psum_clear 1,0,1,0. wb_req twice (oc_idx 0,1). One done pulse.
- M=3,p=2,t=1,C=1,q=r=1 -> n_oc=2, n_ic=1; 2 passes, filter_base 0,18 (R=S=3), psum_clear 1,1.
- TIMEOUT=16, PE_array_complete never asserted -> err=1, err_code=2 exactly 16 cycles after entering WAIT. begin_layer is not reissued. abort then clears err.
- cfg_M=0 with start -> ERR with err_code=1 the next cycle; begin_layer never pulses.
- Pulse PE_array_complete in the ISSUE cycle, then the real complete 5 cycles later -> only the second advances ic_idx.
- abort in WAIT of pass 2, then start again -> next begin_layer has filter_base=0, ifmap_base=0, psum_clear=1.

Source files
------------

// File: rtl/rs_layer_sequencer_if.sv
// PE_array / writeback side of the layer sequencer: pass control, bank bases and
// the writeback handshake. The sequencer takes the master modport.
interface rs_layer_sequencer_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned CNT_W  = 16
);
  logic              begin_layer;
  logic              PE_array_complete;
  logic [ADDR_W-1:0] filter_base;
  logic [ADDR_W-1:0] ifmap_base;
  logic              psum_clear;
  logic [CNT_W-1:0]  oc_idx;
  logic [CNT_W-1:0]  ic_idx;
  logic              wb_req;
  logic              wb_ack;

  modport master (
    output begin_layer, filter_base, ifmap_base, psum_clear, oc_idx, ic_idx, wb_req,
    input  PE_array_complete, wb_ack
  );

  modport slave (
    input  begin_layer, filter_base, ifmap_base, psum_clear, oc_idx, ic_idx, wb_req,
    output PE_array_complete, wb_ack
  );
endinterface

// File: rtl/rs_layer_sequencer.sv
// Layer sequencer for the row-stationary PE array. Tiles output channels into groups
// of p*t and input channels into groups of q*r, issues one pass per (oc, ic) group
// pair and hands each finished output group to writeback.
module rs_layer_sequencer #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_M,
  input  logic [CNT_W-1:0]    cfg_C,
  input  logic [7:0]          cfg_H,
  input  logic [7:0]          cfg_W,
  input  logic [4:0]          cfg_R,
  input  logic [3:0]          cfg_S,
  input  logic [4:0]          cfg_p,
  input  logic [4:0]          cfg_r,
  input  logic [4:0]          cfg_t,
  input  logic [2:0]          cfg_q,
  rs_layer_sequencer_if.master pe,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StIssue, StWait, StWb, StDone, StErr
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  m_q, m_d, c_q, c_d;
  logic [7:0]        h_q, h_d, w_q, w_d;
  logic [4:0]        fr_q, fr_d;
  logic [3:0]        fs_q, fs_d;
  logic [4:0]        p_q, p_d, r_q, r_d, t_q, t_d;
  logic [2:0]        q_q, q_d;
  logic [ADDR_W-1:0] fblk_q, fblk_d, iblk_q, iblk_d;
  logic [ADDR_W-1:0] fbase_q, fbase_d, ibase_q, ibase_d;
  logic [CNT_W-1:0]  oc_idx_q, oc_idx_d, ic_idx_q, ic_idx_d;
  // Channels covered by the groups already finished; replaces a ceil() divider.
  logic [CNT_W-1:0]  oc_ch_q, oc_ch_d, ic_ch_q, ic_ch_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [9:0]        pt;
  logic [7:0]        qr;
  logic [26:0]       fblk_full;
  logic [23:0]       iblk_full;
  logic [CNT_W:0]    oc_end, ic_end;
  logic              oc_last, ic_last;
  logic              cfg_zero;

  assign pt        = 10'(p_q) * 10'(t_q);
  assign qr        = 8'(q_q) * 8'(r_q);
  assign fblk_full = 27'(pt) * 27'(qr) * 27'(fr_q) * 27'(fs_q);
  assign iblk_full = 24'(qr) * 24'(h_q) * 24'(w_q);

  // A group is the last one once it reaches or passes the configured channel count.
  assign oc_end  = {1'b0, oc_ch_q} + (CNT_W+1)'(pt);
  assign ic_end  = {1'b0, ic_ch_q} + (CNT_W+1)'(qr);
  assign oc_last = oc_end >= {1'b0, m_q};
  assign ic_last = ic_end >= {1'b0, c_q};

  assign cfg_zero = (cfg_M == '0) || (cfg_C == '0) || (cfg_p == '0) || (cfg_t == '0) ||
                    (cfg_q == '0) || (cfg_r == '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      m_q        <= '0;
      c_q        <= '0;
      h_q        <= '0;
      w_q        <= '0;
      fr_q       <= '0;
      fs_q       <= '0;
      p_q        <= '0;
      r_q        <= '0;
      t_q        <= '0;
      q_q        <= '0;
      fblk_q     <= '0;
      iblk_q     <= '0;
      fbase_q    <= '0;
      ibase_q    <= '0;
      oc_idx_q   <= '0;
      ic_idx_q   <= '0;
      oc_ch_q    <= '0;
      ic_ch_q    <= '0;
      tmo_q      <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      c_q        <= c_d;
      h_q        <= h_d;
      w_q        <= w_d;
      fr_q       <= fr_d;
      fs_q       <= fs_d;
      p_q        <= p_d;
      r_q        <= r_d;
      t_q        <= t_d;
      q_q        <= q_d;
      fblk_q     <= fblk_d;
      iblk_q     <= iblk_d;
      fbase_q    <= fbase_d;
      ibase_q    <= ibase_d;
      oc_idx_q   <= oc_idx_d;
      ic_idx_q   <= ic_idx_d;
      oc_ch_q    <= oc_ch_d;
      ic_ch_q    <= ic_ch_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and datapath updates; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    c_d        = c_q;
    h_d        = h_q;
    w_d        = w_q;
    fr_d       = fr_q;
    fs_d       = fs_q;
    p_d        = p_q;
    r_d        = r_q;
    t_d        = t_q;
    q_d        = q_q;
    fblk_d     = fblk_q;
    iblk_d     = iblk_q;
    fbase_d    = fbase_q;
    ibase_d    = ibase_q;
    oc_idx_d   = oc_idx_q;
    ic_idx_d   = ic_idx_q;
    oc_ch_d    = oc_ch_q;
    ic_ch_d    = ic_ch_q;
    tmo_d      = tmo_q;
    err_code_d = err_code_q;

    if (abort) begin
      state_d    = StIdle;
      fbase_d    = '0;
      ibase_d    = '0;
      oc_idx_d   = '0;
      ic_idx_d   = '0;
      oc_ch_d    = '0;
      ic_ch_d    = '0;
      tmo_d      = '0;
      err_code_d = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_d  = cfg_M;
            c_d  = cfg_C;
            h_d  = cfg_H;
            w_d  = cfg_W;
            fr_d = cfg_R;
            fs_d = cfg_S;
            p_d  = cfg_p;
            r_d  = cfg_r;
            t_d  = cfg_t;
            q_d  = cfg_q;
            if (cfg_zero) begin
              state_d    = StErr;
              err_code_d = 2'd1;
            end else begin
              state_d = StLoad;
            end
          end
        end
        StLoad: begin
          fblk_d   = ADDR_W'(fblk_full);
          iblk_d   = ADDR_W'(iblk_full);
          fbase_d  = '0;
          ibase_d  = '0;
          oc_idx_d = '0;
          ic_idx_d = '0;
          oc_ch_d  = '0;
          ic_ch_d  = '0;
          state_d  = StIssue;
        end
        StIssue: begin
          // A complete seen here belongs to the previous pass and is dropped.
          tmo_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          tmo_d = tmo_q + 1'b1;
          if (pe.PE_array_complete) begin
            fbase_d = fbase_q + fblk_q;
            if (ic_last) begin
              state_d = StWb;
            end else begin
              ic_idx_d = ic_idx_q + 1'b1;
              ic_ch_d  = ic_end[CNT_W-1:0];
              ibase_d  = ibase_q + iblk_q;
              state_d  = StIssue;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d    = StErr;
            err_code_d = 2'd2;
          end
        end
        StWb: begin
          if (pe.wb_ack) begin
            if (oc_last) begin
              state_d = StDone;
            end else begin
              oc_idx_d = oc_idx_q + 1'b1;
              oc_ch_d  = oc_end[CNT_W-1:0];
              ic_idx_d = '0;
              ic_ch_d  = '0;
              ibase_d  = '0;
              state_d  = StIssue;
            end
          end
        end
        StDone: state_d = StIdle;
        StErr:  state_d = StErr;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    pe.begin_layer = (state_q == StIssue);
    pe.wb_req      = (state_q == StWb);
    pe.filter_base = fbase_q;
    pe.ifmap_base  = ibase_q;
    pe.oc_idx      = oc_idx_q;
    pe.ic_idx      = ic_idx_q;
    pe.psum_clear  = ((state_q == StIssue) || (state_q == StWait)) && (ic_idx_q == '0);
    busy           = (state_q == StLoad) || (state_q == StIssue) || (state_q == StWait) ||
                     (state_q == StWb) || (state_q == StDone);
    done           = (state_q == StDone);
    err            = (state_q == StErr);
    err_code       = err_code_q;
  end

endmodule

// File: tb/tb_rs_layer_sequencer.sv
// Directed bench for rs_layer_sequencer: a small tiling model fills a scoreboard of
// expected passes and writebacks that is drained as the DUT issues them.
module tb_rs_layer_sequencer;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_M, cfg_C;
  logic [7:0]       cfg_H, cfg_W;
  logic [4:0]       cfg_R;
  logic [3:0]       cfg_S;
  logic [4:0]       cfg_p, cfg_r, cfg_t;
  logic [2:0]       cfg_q;
  logic             busy, done, err;
  logic [1:0]       err_code;

  rs_layer_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) pe ();

  rs_layer_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_M(cfg_M), .cfg_C(cfg_C), .cfg_H(cfg_H), .cfg_W(cfg_W), .cfg_R(cfg_R),
    .cfg_S(cfg_S), .cfg_p(cfg_p), .cfg_r(cfg_r), .cfg_t(cfg_t), .cfg_q(cfg_q),
    .pe(pe), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] fb;
    logic [ADDR_W-1:0] ib;
    logic              pc;
    logic [CNT_W-1:0]  oc;
    logic [CNT_W-1:0]  ic;
  } pass_t;

  pass_t            exp_q[$];
  logic [CNT_W-1:0] wb_q[$];
  int checks = 0;
  int errors = 0;
  int bl_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (pe.begin_layer === 1'b1) bl_cnt <= bl_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference tiling: ceil-divide channels, filter base runs across the whole layer.
  task automatic push_layer(input int m, c, p, q, r, t, fr, fs, h, w);
    int n_oc, n_ic, fblk, iblk, fb;
    pass_t e;
    n_oc = (m + p * t - 1) / (p * t);
    n_ic = (c + q * r - 1) / (q * r);
    fblk = p * t * q * r * fr * fs;
    iblk = q * r * h * w;
    fb   = 0;
    for (int o = 0; o < n_oc; o++) begin
      for (int i = 0; i < n_ic; i++) begin
        e.fb = ADDR_W'(fb);
        e.ib = ADDR_W'(i * iblk);
        e.pc = (i == 0);
        e.oc = CNT_W'(o);
        e.ic = CNT_W'(i);
        exp_q.push_back(e);
        fb += fblk;
      end
      wb_q.push_back(CNT_W'(o));
    end
  endtask

  task automatic set_cfg(input int m, c, p, q, r, t, fr, fs, h, w);
    cfg_M = CNT_W'(m); cfg_C = CNT_W'(c);
    cfg_p = 5'(p); cfg_q = 3'(q); cfg_r = 5'(r); cfg_t = 5'(t);
    cfg_R = 5'(fr); cfg_S = 4'(fs); cfg_H = 8'(h); cfg_W = 8'(w);
  endtask

  task automatic start_layer(input int m, c, p, q, r, t, fr, fs, h, w);
    set_cfg(m, c, p, q, r, t, fr, fs, h, w);
    push_layer(m, c, p, q, r, t, fr, fs, h, w);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble cfg: the DUT must be using its latched copy.
    set_cfg(7, 9, 3, 2, 2, 3, 1, 1, 2, 2);
    check("busy_in_load", busy, 1);
    check("no_bl_in_load", pe.begin_layer, 0);
  endtask

  // mode 0: normal pass; 1: stale complete in ISSUE; 2: abort three cycles into WAIT
  task automatic serve_pass(input int lat, input int mode);
    int n;
    pass_t e;
    n = 0;
    while (pe.begin_layer !== 1'b1 && n < 100) begin tick(); n++; end
    check("begin_layer_seen", pe.begin_layer, 1);
    check("sb_pass_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("filter_base", pe.filter_base, e.fb);
      check("ifmap_base", pe.ifmap_base, e.ib);
      check("psum_clear", pe.psum_clear, e.pc);
      check("oc_idx", pe.oc_idx, e.oc);
      check("ic_idx", pe.ic_idx, e.ic);
    end
    pe.PE_array_complete = (mode == 1);
    tick();
    pe.PE_array_complete = 1'b0;
    check("begin_layer_1cyc", pe.begin_layer, 0);
    if (mode == 1) begin
      tick();
      check("stale_ignored_ic", pe.ic_idx, e.ic);
      check("stale_ignored_bl", pe.begin_layer, 0);
      for (int k = 2; k < lat; k++) tick();
    end else if (mode == 2) begin
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      return;
    end else begin
      for (int k = 1; k < lat; k++) tick();
    end
    check("hold_filter_base", pe.filter_base, e.fb);
    pe.PE_array_complete = 1'b1;
    tick();
    pe.PE_array_complete = 1'b0;
  endtask

  task automatic serve_wb();
    int n;
    logic [CNT_W-1:0] o;
    n = 0;
    while (pe.wb_req !== 1'b1 && n < 100) begin tick(); n++; end
    check("wb_req_seen", pe.wb_req, 1);
    check("sb_wb_nonempty", wb_q.size() != 0, 1);
    if (wb_q.size() != 0) begin
      o = wb_q.pop_front();
      check("wb_oc_idx", pe.oc_idx, o);
    end
    tick();
    check("wb_req_held", pe.wb_req, 1);
    check("no_bl_in_wb", pe.begin_layer, 0);
    pe.wb_ack = 1'b1;
    tick();
    pe.wb_ack = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    check("done_seen", done, 1);
    check("busy_in_done", busy, 1);
    tick();
    check("done_1cyc", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    wb_q.delete();
  endtask

  initial begin
    int bl_base;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pe.PE_array_complete = 1'b0; pe.wb_ack = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_begin_layer", pe.begin_layer, 0);
    check("rst_wb_req", pe.wb_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_filter_base", pe.filter_base, 0);
    check("rst_ifmap_base", pe.ifmap_base, 0);
    check("rst_psum_clear", pe.psum_clear, 0);
    check("rst_oc_idx", pe.oc_idx, 0);
    check("rst_ic_idx", pe.ic_idx, 0);

    // Layer 1: 2x2 groups, four passes.
    bl_base = bl_cnt;
    start_layer(2, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    serve_pass(10, 0); serve_pass(10, 0); serve_wb();
    serve_pass(10, 0); serve_pass(10, 0); serve_wb();
    wait_done();
    check("l1_pass_count", bl_cnt - bl_base, 4);
    check("l1_sb_drained", exp_q.size() + wb_q.size(), 0);

    // Layer 2: partial last output group.
    bl_base = bl_cnt;
    start_layer(3, 1, 2, 1, 1, 1, 3, 3, 5, 5);
    serve_pass(10, 0); serve_wb();
    serve_pass(10, 0); serve_wb();
    wait_done();
    check("l2_pass_count", bl_cnt - bl_base, 2);

    // Timeout: no complete ever arrives.
    bl_base = bl_cnt;
    start_layer(2, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    begin
      int n;
      n = 0;
      while (pe.begin_layer !== 1'b1 && n < 100) begin tick(); n++; end
    end
    check("to_begin_layer", pe.begin_layer, 1);
    for (int k = 0; k < int'(TIMEOUT); k++) tick();
    check("to_err_early", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_err_code", err_code, 2);
    check("to_busy", busy, 0);
    tick(); tick();
    check("to_err_sticky", err, 1);
    check("to_no_reissue", bl_cnt - bl_base, 1);
    do_abort();
    check("to_abort_err", err, 0);
    check("to_abort_code", err_code, 0);
    check("to_abort_busy", busy, 0);

    // Zero config, then a start while in ERR.
    bl_base = bl_cnt;
    set_cfg(0, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zc_err", err, 1);
    check("zc_err_code", err_code, 1);
    check("zc_busy", busy, 0);
    set_cfg(2, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("zc_start_ignored", err_code, 1);
    check("zc_no_begin_layer", bl_cnt - bl_base, 0);
    do_abort();
    check("zc_abort_err", err, 0);

    // Stale complete in ISSUE, abort during pass 2, restart from scratch.
    start_layer(2, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    serve_pass(5, 1);
    serve_pass(10, 2);
    check("ab_busy", busy, 0);
    check("ab_ic_idx", pe.ic_idx, 0);
    check("ab_filter_base", pe.filter_base, 0);
    exp_q.delete();
    wb_q.delete();
    start_layer(2, 2, 1, 1, 1, 1, 3, 3, 5, 5);
    serve_pass(10, 0); serve_pass(10, 0); serve_wb();
    serve_pass(10, 0); serve_pass(10, 0); serve_wb();
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
